// File: rtl/blink_gen.sv
// Burst LED blinker: on TRIG, emits CNT blinks of ON_TICKS lit / OFF_TICKS unlit cycles,
// then pulses DONE. ABORT or CLR abandon a burst without DONE.
module blink_gen #(
  parameter logic [23:0] ON_TICKS  = 24'd5000000,
  parameter logic [23:0] OFF_TICKS = 24'd5000000,
  parameter bit          ACT_LOW   = 1'b1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       TRIG,
  input  logic [3:0] CNT,
  input  logic       ABORT,
  output logic       LED,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        led_q, led_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 24'd1;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (ABORT) begin
      state_d = StIdle;
      timer_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timer_d = '0;
          if (TRIG) begin
            if (CNT != 4'd0) begin
              state_d = StOn;
              cnt_d   = CNT;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StOn: begin
          if (timer_q == ON_TICKS - 24'd1) begin
            state_d = StOff;
            timer_d = '0;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        StOff: begin
          if (timer_q == OFF_TICKS - 24'd1) begin
            timer_d = '0;
            if (cnt_q == 4'd0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StOn;
            end
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    led_d  = (state_d == StOn) ? ~ACT_LOW : ACT_LOW;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      led_q   <= ACT_LOW;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LED  = led_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_blink_gen.sv
// Scoreboard bench for blink_gen: a burst-timeline reference model queues expected
// {LED,BUSY,DONE} per edge; a monitor pops and compares after every rising edge.
module tb_blink_gen;

  localparam int  OnT  = 3;
  localparam int  OffT = 2;
  localparam int  Per  = OnT + OffT;
  localparam bit  ActL = 1'b1;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       TRIG = 1'b0;
  logic [3:0] CNT = 4'd0;
  logic       ABORT = 1'b0;
  logic       LED, BUSY, DONE;

  blink_gen #(
    .ON_TICKS (24'(OnT)),
    .OFF_TICKS(24'(OffT)),
    .ACT_LOW  (ActL)
  ) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .TRIG (TRIG),
    .CNT  (CNT),
    .ABORT(ABORT),
    .LED  (LED),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  logic [2:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: a burst is a timeline anchored at its start edge.
  int edge_no = 0;
  int start_edge = 0;
  int burst_n = 0;
  bit active = 1'b0;
  bit cur_busy = 1'b0;

  task automatic step(input bit clr, input bit trig, input int c, input bit abt);
    int d;
    bit lit, busy, done;
    @(negedge CLK);
    CLR = clr;
    TRIG = trig;
    CNT = 4'(c);
    ABORT = abt;
    edge_no++;
    if (clr || abt) active = 1'b0;
    else if (trig && !cur_busy) begin
      active = 1'b1;
      start_edge = edge_no;
      burst_n = c;
    end
    lit = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    if (active) begin
      d = edge_no - start_edge;
      if (d > burst_n * Per) active = 1'b0;
      else begin
        busy = (d < burst_n * Per);
        lit  = busy && ((d % Per) < OnT);
        done = (d == burst_n * Per);
      end
    end
    cur_busy = busy;
    exp_q.push_back({lit ? ~ActL : ActL, busy, done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: one comparison per rising edge once expectations exist.
  initial begin
    logic [2:0] exp_v;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if ({LED, BUSY, DONE} !== exp_v) begin
          miscompares++;
          $display("FAIL outputs at t=%0t: got LED=%b BUSY=%b DONE=%b, required LED=%b BUSY=%b DONE=%b",
                   $time, LED, BUSY, DONE, exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    // Reset, including TRIG/ABORT overridden by CLR.
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 5, 1'b1);
    idle(2);
    // Two-blink burst.
    step(1'b0, 1'b1, 2, 1'b0);
    idle(12);
    // Zero-count trigger.
    step(1'b0, 1'b1, 0, 1'b0);
    idle(3);
    // Retrigger while busy is ignored.
    step(1'b0, 1'b1, 3, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1, 1'b0);
    idle(14);
    // Abort mid-burst, then a fresh single blink.
    step(1'b0, 1'b1, 15, 1'b0);
    idle(6);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1, 1'b0);
    idle(7);
    // TRIG with ABORT, then CLR mid-burst, then normal trigger.
    step(1'b0, 1'b1, 4, 1'b1);
    idle(3);
    step(1'b0, 1'b1, 4, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1, 1'b0);
    idle(7);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
           ($urandom_range(0, 63) == 0));
    end
    idle(4);
    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blink_gen.md
BLINK_GEN -- requirements
Module: blink_gen

Interface
REQ-001 Parameter ON_TICKS, default 24'd5000000, LED-on duration per blink in CLK cycles (100 ms at 50 MHz), legal range 1..2^24-1.
REQ-002 Parameter OFF_TICKS, default 24'd5000000, LED-off gap after each blink in CLK cycles, legal range 1..2^24-1.
REQ-003 Parameter ACT_LOW, default 1, LED polarity: 1 = LED pin driven 0 when lit, 0 = driven 1 when lit.
REQ-004 CLK  input  1  50 MHz system clock, all logic on rising edge.
REQ-005 CLR  input  1  synchronous, active-high reset.
REQ-006 TRIG  input  1  single-cycle request to start a blink burst.
REQ-007 CNT  input  4  number of blinks in the burst, sampled with TRIG.
REQ-008 ABORT  input  1  level, terminates any burst immediately.
REQ-009 LED  output  1  registered LED drive, polarity per ACT_LOW.
REQ-010 BUSY  output  1  registered, high while a burst is in progress.
REQ-011 DONE  output  1  registered single-cycle pulse on normal burst completion.

Function
REQ-012 The block SHALL implement states IDLE, ON, OFF with a 24-bit phase timer and a 4-bit remaining-blink counter.
REQ-013 In IDLE, TRIG=1 with CNT>0 and ABORT=0 at edge k SHALL latch CNT, enter ON, and show lit LED and BUSY=1 from edge k onward (visible in cycle k+1).
REQ-014 In IDLE, TRIG=1 with CNT=0 SHALL stay in IDLE, leave LED unlit and BUSY=0, and assert DONE for exactly one cycle after edge k.
REQ-015 ON SHALL last exactly ON_TICKS cycles, then OFF SHALL last exactly OFF_TICKS cycles; the remaining-blink counter SHALL decrement on each ON-to-OFF transition.
REQ-016 At the end of OFF with remaining count nonzero the block SHALL re-enter ON; with remaining count zero it SHALL enter IDLE, drop BUSY, and pulse DONE for one cycle on the same edge.
REQ-017 Total burst duration from the TRIG edge to the DONE edge SHALL be CNT*(ON_TICKS+OFF_TICKS) cycles.
REQ-018 TRIG while BUSY=1 SHALL be ignored, with no queuing and no effect on the count.
REQ-019 ABORT=1 in any state SHALL force IDLE, unlit LED and BUSY=0 on the next edge, with no DONE pulse.
REQ-020 ABORT and TRIG asserted together SHALL resolve to ABORT, so no burst starts.
REQ-021 DONE SHALL never be asserted on two consecutive cycles and SHALL never coincide with BUSY=1.
REQ-022 The timer SHALL reload to zero on every state change, so it never wraps within a phase.
REQ-023 LED SHALL be unlit in IDLE and OFF and lit only in ON, after polarity mapping.

Reset
REQ-024 CLR=1 at a rising edge SHALL force IDLE, timer=0, count=0, LED unlit (LED=1 when ACT_LOW=1), BUSY=0, DONE=0, overriding ABORT and TRIG.
REQ-025 CLR asserted mid-burst SHALL abandon the burst with no DONE, and the first TRIG after CLR deasserts SHALL be honoured normally.

Verification (ON_TICKS=3, OFF_TICKS=2, ACT_LOW=1)
REQ-026 Reset, then TRIG with CNT=2 -> LED pattern 0,0,0,1,1,0,0,0,1,1, BUSY high for 10 cycles, DONE pulse on the 10th edge, then LED=1 and BUSY=0.
REQ-027 TRIG with CNT=0 -> DONE=1 for one cycle, BUSY stays 0, LED stays 1.
REQ-028 TRIG with CNT=3, then a second TRIG with CNT=1 at cycle 4 -> exactly 3 blinks, DONE after 15 cycles.
REQ-029 TRIG with CNT=15, ABORT at cycle 7 -> LED=1 and BUSY=0 from the next cycle, no DONE; a subsequent TRIG with CNT=1 gives 1 blink and DONE after 5 cycles.
REQ-030 TRIG and ABORT in the same cycle -> no burst, no DONE; CLR at cycle 2 of a CNT=4 burst -> all outputs at reset values, no DONE.
